serv_decode_q: RTL

SERV_DECODE_Q -- requirements
Module: serv_decode_q

---
 rtl/serv_decode_pkg.sv | 44 ++++
 rtl/serv_decode_fifo.sv | 55 +++++
 rtl/serv_decode_q.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serv_decode_pkg.sv
// Shared opcode/funct7 constants, output-stage state encoding and decode payload.
package serv_decode_pkg;

  localparam int unsigned IW = 30;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MDU  = 7'h01;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ostate_t;

  typedef struct packed {
    logic       mem_op;
    logic       branch_op;
    logic       shift_op;
    logic       slt_op;
    logic       rd_op;
    logic       alu_sub;
    logic       csr_op;
    logic       ctrl_mret;
    logic       e_op;
    logic       illegal;
    logic       mdu_op;
    logic [2:0] funct3;
    logic [1:0] alu_bool_op;
    logic [3:0] immdec_en;
  } dec_t;

endpackage

// File: rtl/serv_decode_fifo.sv
// Instruction buffer: power-of-two circular FIFO, storage left unreset.
module serv_decode_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);
  assign do_push = i_push & ~o_full & ~i_flush;
  assign do_pop  = i_pop & ~o_empty & ~i_flush;
  assign o_rdata = mem[rptr];

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      o_count <= o_count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= i_wdata;
  end

endmodule

// File: rtl/serv_decode_q.sv
// Buffered RV32I instruction pre-decoder. Optional M-extension decode: SERV_DECODE_MDU_EN.
module serv_decode_q
  import serv_decode_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned REG_OUT = 0
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [29:0]            i_wb_rdt,
  input  logic                   i_wb_en,
  output logic                   o_wb_ready,
  input  logic                   i_flush,
  input  logic                   i_dec_ready,
  output logic                   o_dec_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_mem_op,
  output logic                   o_branch_op,
  output logic                   o_shift_op,
  output logic                   o_slt_op,
  output logic                   o_rd_op,
  output logic                   o_alu_sub,
  output logic                   o_csr_op,
  output logic                   o_ctrl_mret,
  output logic                   o_e_op,
  output logic                   o_illegal,
  output logic                   o_mdu_op,
  output logic [2:0]             o_funct3,
  output logic [1:0]             o_alu_bool_op,
  output logic [3:0]             o_immdec_en
);

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] fifo_rdata;
  logic          pop;
  dec_t          dec_c;
  dec_t          dec_out;
  dec_t          dec_vis;

  assign o_wb_ready = ~fifo_full;
  assign fifo_push  = i_wb_en & ~fifo_full & ~i_flush;
  assign pop        = o_dec_valid & i_dec_ready;

  serv_decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IW)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (fifo_push),
    .i_wdata (i_wb_rdt),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_count (o_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Instruction fields (word holds instruction bits [31:2]).
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       b21;
  logic       unused_src;

  assign op         = fifo_rdata[4:0];
  assign f3         = fifo_rdata[12:10];
  assign f7         = fifo_rdata[29:23];
  assign b21        = fifo_rdata[19];
  assign unused_src = ^{fifo_rdata[9:5], fifo_rdata[18:13], fifo_rdata[22:20]};

  logic is_load, is_misc, is_opimm, is_auipc, is_store, is_op;
  logic is_lui, is_branch, is_jalr, is_jal, is_system;
  logic is_alu, is_slt, is_mdu, is_legal;
  logic t_i, t_s, t_b, t_u, t_j;

  assign is_load   = (op == OP_LOAD);
  assign is_misc   = (op == OP_MISC_MEM);
  assign is_opimm  = (op == OP_OP_IMM);
  assign is_auipc  = (op == OP_AUIPC);
  assign is_store  = (op == OP_STORE);
  assign is_op     = (op == OP_OP);
  assign is_lui    = (op == OP_LUI);
  assign is_branch = (op == OP_BRANCH);
  assign is_jalr   = (op == OP_JALR);
  assign is_jal    = (op == OP_JAL);
  assign is_system = (op == OP_SYSTEM);
  assign is_alu    = is_op | is_opimm;
  assign is_slt    = is_alu & (f3[2:1] == 2'b01);

`ifdef SERV_DECODE_MDU_EN
  assign is_mdu = is_op & (f7 == F7_MDU);
`else
  assign is_mdu = 1'b0;
`endif

  assign is_legal = is_load | is_misc | is_opimm | is_auipc | is_store | is_lui |
                    is_branch | is_jalr | is_jal | is_system |
                    (is_op & ((f7 == F7_BASE) | (f7 == F7_ALT) | is_mdu));

  // Immediate format classes.
  assign t_i = is_load | is_opimm | is_jalr | is_system | is_misc;
  assign t_s = is_store;
  assign t_b = is_branch;
  assign t_u = is_lui | is_auipc;
  assign t_j = is_jal;

  // Decode of the buffer head word.
  always_comb begin
    dec_c             = '0;
    dec_c.mem_op      = is_load | is_store;
    dec_c.branch_op   = is_branch | is_jal | is_jalr;
    dec_c.shift_op    = is_alu & (f3[1:0] == 2'b01);
    dec_c.slt_op      = is_slt;
    dec_c.rd_op       = ~(is_store | is_branch | is_misc);
    dec_c.alu_sub     = is_branch | is_slt | (is_op & f7[5] & (f3 == 3'b000));
    dec_c.csr_op      = is_system & (f3 != 3'b000);
    dec_c.ctrl_mret   = is_system & (f3 == 3'b000) & b21;
    dec_c.e_op        = is_system & (f3 == 3'b000) & ~b21;
    dec_c.illegal     = ~is_legal;
    dec_c.mdu_op      = is_mdu;
    dec_c.funct3      = f3;
    dec_c.alu_bool_op = is_alu ? f3[1:0] : 2'b00;
    dec_c.immdec_en   = {t_b | t_i | t_j | t_s | t_u, t_i | t_j | t_u, t_j | t_u, t_b | t_s};
  end

  if (REG_OUT == 0) begin : g_comb

    assign o_dec_valid = ~fifo_empty;
    assign fifo_pop    = pop & ~i_flush;
    assign dec_out     = dec_c;

  end else begin : g_reg

    ostate_t state_q;
    ostate_t state_d;
    logic    load;
    dec_t    dec_q;

    // Output stage state register.
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_EMPTY;
      else          state_q <= state_d;
    end

    // Output stage next-state and reload control.
    always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (i_flush) begin
        state_d = S_EMPTY;
      end else begin
        case (state_q)
          S_EMPTY: begin
            if (!fifo_empty) begin
              load    = 1'b1;
              state_d = S_FULL;
            end
          end
          S_FULL: begin
            if (pop) begin
              if (fifo_empty) state_d = S_EMPTY;
              else            load    = 1'b1;
            end
          end
          default: state_d = S_EMPTY;
        endcase
      end
    end

    // Registered decode payload.
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)     dec_q <= '0;
      else if (i_flush) dec_q <= '0;
      else if (load)    dec_q <= dec_c;
    end

    assign o_dec_valid = (state_q == S_FULL);
    assign fifo_pop    = load;
    assign dec_out     = dec_q;

  end

  assign dec_vis = o_dec_valid ? dec_out : '0;

  assign o_mem_op      = dec_vis.mem_op;
  assign o_branch_op   = dec_vis.branch_op;
  assign o_shift_op    = dec_vis.shift_op;
  assign o_slt_op      = dec_vis.slt_op;
  assign o_rd_op       = dec_vis.rd_op;
  assign o_alu_sub     = dec_vis.alu_sub;
  assign o_csr_op      = dec_vis.csr_op;
  assign o_ctrl_mret   = dec_vis.ctrl_mret;
  assign o_e_op        = dec_vis.e_op;
  assign o_illegal     = dec_vis.illegal;
  assign o_mdu_op      = dec_vis.mdu_op;
  assign o_funct3      = dec_vis.funct3;
  assign o_alu_bool_op = dec_vis.alu_bool_op;
  assign o_immdec_en   = dec_vis.immdec_en;

endmodule
